// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
//
// Contents:
//   acc_mode_e   : load/store access modes in funct3 encoding
//   dmem_state_e : responder FSM states
//   dmem_req_t   : request fields latched at accept
//   mode_ok_load / mode_ok_store : mode legality per direction
package dmem_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } acc_mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } dmem_state_e;

    // Mode is kept as raw bits: illegal encodings must survive latching
    // so they can be reported in the ACCESS cycle.
    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  mode;
        logic [31:0] wdata;
    } dmem_req_t;

    function automatic logic mode_ok_load(input logic [2:0] mode);
        return (mode == MEM_B)  || (mode == MEM_H) || (mode == MEM_W) ||
               (mode == MEM_BU) || (mode == MEM_HU);
    endfunction

    // Unsigned variants have no meaning for stores.
    function automatic logic mode_ok_store(input logic [2:0] mode);
        return (mode == MEM_B) || (mode == MEM_H) || (mode == MEM_W);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for the data-memory responder.
//
// Ports:
//   mode_i       access mode (funct3 encoding)
//   addr_lo_i    byte offset within the word
//   wdata_i      LSB-aligned store data
//   raw_i        word read from the array
//   be_o         byte enables for a store
//   wdata_al_o   store data replicated onto the selected lanes
//   rdata_ext_o  selected load lane, sign- or zero-extended
//   misalign_o   half at odd offset, or word at non-zero offset
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  mode_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] raw_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_al_o,
    output logic [31:0] rdata_ext_o,
    output logic        misalign_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = raw_i[7:0];
        case (addr_lo_i)
            2'd0: byte_sel = raw_i[7:0];
            2'd1: byte_sel = raw_i[15:8];
            2'd2: byte_sel = raw_i[23:16];
            2'd3: byte_sel = raw_i[31:24];
            default: byte_sel = raw_i[7:0];
        endcase
    end

    assign half_sel = addr_lo_i[1] ? raw_i[31:16] : raw_i[15:0];

    always_comb begin
        be_o        = 4'b0000;
        wdata_al_o  = 32'h0;
        rdata_ext_o = 32'h0;
        misalign_o  = 1'b0;
        case (mode_i)
            MEM_B: begin
                be_o        = 4'b0001 << addr_lo_i;
                wdata_al_o  = {4{wdata_i[7:0]}};
                rdata_ext_o = {{24{byte_sel[7]}}, byte_sel};
            end
            MEM_BU: begin
                be_o        = 4'b0001 << addr_lo_i;
                wdata_al_o  = {4{wdata_i[7:0]}};
                rdata_ext_o = {24'h0, byte_sel};
            end
            MEM_H: begin
                be_o        = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_al_o  = {2{wdata_i[15:0]}};
                rdata_ext_o = {{16{half_sel[15]}}, half_sel};
                misalign_o  = addr_lo_i[0];
            end
            MEM_HU: begin
                be_o        = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_al_o  = {2{wdata_i[15:0]}};
                rdata_ext_o = {16'h0, half_sel};
                misalign_o  = addr_lo_i[0];
            end
            MEM_W: begin
                be_o        = 4'b1111;
                wdata_al_o  = wdata_i;
                rdata_ext_o = raw_i;
                misalign_o  = (addr_lo_i != 2'd0);
            end
            default: begin
                be_o        = 4'b0000;
                wdata_al_o  = 32'h0;
                rdata_ext_o = 32'h0;
                misalign_o  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with configurable wait states.
//
// State table:
//   IDLE   | ready for a request; latches it on handshake
//   WAIT   | burns WAIT_CYCLES cycles on the down-counter
//   ACCESS | legality check, store commit or array read, result registered
//   RESP   | response held until rsp_ready
//
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_rd/req_wr         load / store select
//   req_addr              byte address
//   req_acc_mode          funct3 access mode
//   req_wdata             LSB-aligned store data
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             extended load data, 0 for stores and errors
//   rsp_err               illegal request, no access performed
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_acc_mode,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // Counter is loaded with N-1 so that WAIT lasts exactly N cycles.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    dmem_state_e state_q, state_d;
    dmem_req_t   req_q, req_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic             accept;
    logic [IDX_W-1:0] idx;
    logic [31:0]      raw;
    logic [3:0]       be;
    logic [31:0]      wdata_al;
    logic [31:0]      rdata_ext;
    logic             misalign;
    logic             mode_ok;
    logic             cmd_ok;
    logic             range_ok;
    logic             access_err;
    logic             mem_we;

    assign req_ready = rst && (state_q == IDLE);
    assign accept    = req_valid && req_ready;

    assign idx = req_q.addr[IDX_W+1:2];
    assign raw = mem[idx];

    dmem_lane_align u_align (
        .mode_i      (req_q.mode),
        .addr_lo_i   (req_q.addr[1:0]),
        .wdata_i     (req_q.wdata),
        .raw_i       (raw),
        .be_o        (be),
        .wdata_al_o  (wdata_al),
        .rdata_ext_o (rdata_ext),
        .misalign_o  (misalign)
    );

    assign mode_ok    = req_q.wr ? mode_ok_store(req_q.mode) : mode_ok_load(req_q.mode);
    assign cmd_ok     = req_q.rd ^ req_q.wr;
    assign range_ok   = ({2'b00, req_q.addr[31:2]} < 32'(DEPTH_WORDS));
    assign access_err = !(mode_ok && cmd_ok && range_ok && !misalign);
    assign mem_we     = rst && (state_q == ACCESS) && req_q.wr && !access_err;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_d.rd    = req_rd;
                    req_d.wr    = req_wr;
                    req_d.addr  = req_addr;
                    req_d.mode  = req_acc_mode;
                    req_d.wdata = req_wdata;
                    cnt_d       = WAIT_LOAD;
                    state_d     = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACCESS: begin
                err_d   = access_err;
                rdata_d = (!access_err && req_q.rd) ? rdata_ext : 32'h0;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            req_q   <= '0;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata_al[8*i +: 8];
                end
            end
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam logic [2:0] M_B  = 3'b000;
    localparam logic [2:0] M_H  = 3'b001;
    localparam logic [2:0] M_W  = 3'b010;
    localparam logic [2:0] M_BU = 3'b100;
    localparam logic [2:0] M_HU = 3'b101;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_rd;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [2:0]  req_acc_mode;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_bad = 0;
    int   since_acc = 0;
    logic prev_valid = 1'b0;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rd       (req_rd),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .req_acc_mode (req_acc_mode),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on each completed handshake and
    // checks the accept-to-valid latency (accept cycle counted as cycle 0).
    always @(negedge clk) begin
        if (req_valid && req_ready) since_acc = 0;
        else since_acc++;
        if (rst && rsp_valid && !prev_valid)
            chk("latency", since_acc, 32'd3);
        if (rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_rsp", {31'b0, rsp_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
            end
        end
        prev_valid = rst && rsp_valid;
    end

    task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [2:0] mode, input logic [31:0] wd,
                         input logic want_rsp, input logic [31:0] erd, input logic eerr);
        int n;
        @(posedge clk); #1;
        req_valid    = 1'b1;
        req_rd       = rd;
        req_wr       = wr;
        req_addr     = addr;
        req_acc_mode = mode;
        req_wdata    = wd;
        if (want_rsp) sb.push_back('{erd, eerr});
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 40) begin
                chk("issue_timeout", {31'b0, req_ready}, 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_rd    = 1'b0;
        req_wr    = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 32'd0);
    endtask

    task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [2:0] mode, input logic [31:0] wd,
                       input logic [31:0] erd, input logic eerr);
        issue(rd, wr, addr, mode, wd, 1'b1, erd, eerr);
        drain();
    endtask

    initial begin
        int n;
        rst = 1'b0;
        req_valid = 1'b0; req_rd = 1'b0; req_wr = 1'b0;
        req_addr = 32'h0; req_acc_mode = 3'b000; req_wdata = 32'h0;
        rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_err", {31'b0, rsp_err}, 32'd0);
        chk("rst_ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {31'b0, req_ready}, 32'd1);

        // Basic store/load and lane extraction.
        txn(1'b0, 1'b1, 32'h10, M_W,  32'hDEADBEEF, 32'h0,        1'b0);
        txn(1'b1, 1'b0, 32'h10, M_W,  32'h0,        32'hDEADBEEF, 1'b0);
        txn(1'b1, 1'b0, 32'h13, M_B,  32'h0,        32'hFFFFFFDE, 1'b0);
        txn(1'b1, 1'b0, 32'h13, M_BU, 32'h0,        32'h000000DE, 1'b0);
        txn(1'b1, 1'b0, 32'h10, M_H,  32'h0,        32'hFFFFBEEF, 1'b0);
        txn(1'b1, 1'b0, 32'h12, M_HU, 32'h0,        32'h0000DEAD, 1'b0);
        txn(1'b1, 1'b0, 32'h11, M_B,  32'h0,        32'hFFFFFFBE, 1'b0);

        // Byte store leaves other lanes alone.
        txn(1'b0, 1'b1, 32'h11, M_B,  32'h5A,       32'h0,        1'b0);
        txn(1'b1, 1'b0, 32'h10, M_W,  32'h0,        32'hDEAD5AEF, 1'b0);

        // Half store to upper lanes of another word.
        txn(1'b0, 1'b1, 32'h14, M_W,  32'h00000000, 32'h0,        1'b0);
        txn(1'b0, 1'b1, 32'h16, M_H,  32'hABCD8123, 32'h0,        1'b0);
        txn(1'b1, 1'b0, 32'h14, M_W,  32'h0,        32'h81230000, 1'b0);
        txn(1'b1, 1'b0, 32'h16, M_H,  32'h0,        32'hFFFF8123, 1'b0);

        // Illegal requests.
        txn(1'b0, 1'b1, 32'h12, M_W,  32'h12345678, 32'h0,        1'b1);
        txn(1'b1, 1'b0, 32'h13, M_H,  32'h0,        32'h0,        1'b1);
        txn(1'b1, 1'b0, 32'h10, M_W,  32'h0,        32'hDEAD5AEF, 1'b0);
        txn(1'b0, 1'b1, 32'h10, M_BU, 32'h77,       32'h0,        1'b1);
        txn(1'b1, 1'b0, 32'h1000, M_W, 32'h0,       32'h0,        1'b1);
        txn(1'b1, 1'b0, 32'h10, 3'b011, 32'h0,      32'h0,        1'b1);
        txn(1'b1, 1'b1, 32'h10, M_W,  32'h0,        32'h0,        1'b1);
        txn(1'b0, 1'b0, 32'h10, M_W,  32'h0,        32'h0,        1'b1);
        txn(1'b1, 1'b0, 32'h10, M_W,  32'h0,        32'hDEAD5AEF, 1'b0);
        txn(1'b1, 1'b0, 32'hFFC, M_W, 32'h0,        32'hxxxxxxxx, 1'b0);
        sb.delete();

        // Backpressure: response held while rsp_ready is low.
        @(posedge clk); #1 rsp_ready = 1'b0;
        issue(1'b1, 1'b0, 32'h10, M_W, 32'h0, 1'b1, 32'hDEAD5AEF, 1'b0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
            chk("hold_rdata", rsp_rdata, 32'hDEAD5AEF);
            chk("hold_err", {31'b0, rsp_err}, 32'd0);
            chk("hold_ready", {31'b0, req_ready}, 32'd0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle_after_hs", {31'b0, req_ready}, 32'd1);
        chk("valid_after_hs", {31'b0, rsp_valid}, 32'd0);
        drain();

        // Reset during WAIT drops a pending store.
        txn(1'b0, 1'b1, 32'h20, M_W, 32'hCAFEF00D, 32'h0, 1'b0);
        issue(1'b0, 1'b1, 32'h20, M_W, 32'h11111111, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstmid_valid", {31'b0, rsp_valid}, 32'd0);
            chk("rstmid_ready", {31'b0, req_ready}, 32'd0);
        end
        @(posedge clk); #1 rst = 1'b1;
        txn(1'b1, 1'b0, 32'h20, M_W, 32'h0, 32'hCAFEF00D, 1'b0);

        // Back-to-back loads with rsp_ready high.
        for (int i = 0; i < 4; i++) begin
            txn(1'b0, 1'b1, 32'h40 + 32'(4*i), M_W, 32'h01020304 * 32'(i + 1), 32'h0, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            txn(1'b1, 1'b0, 32'h40 + 32'(4*i), M_W, 32'h0, 32'h01020304 * 32'(i + 1), 1'b0);
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=%0d", n_chk, 0);
        $fatal(1);
    end

endmodule
